// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, reads the synchronous instruction RAM
// and hands one instruction at a time to the decoder over valid/ready.
module instr_fetch #(
   parameter int unsigned            ADDR_W   = 16,
   parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [15:0]       mem_rdata,
   output logic [15:0]       instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_target,
   input  logic              halt,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      S_RST  = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] instr_pc_nxt;
   logic [15:0]       instr_nxt, fetch_count_nxt;
   logic              rd_en_nxt, valid_nxt;
   logic              redirect;

   // Redirect is ignored only while coming out of reset.
   assign redirect = pc_load && (state != S_RST);
   assign mem_addr = pc;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_RST;
         pc          <= RESET_PC;
         mem_rd_en   <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         mem_rd_en   <= rd_en_nxt;
         instr       <= instr_nxt;
         instr_pc    <= instr_pc_nxt;
         instr_valid <= valid_nxt;
         fetch_count <= fetch_count_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_RST:  state_nxt = S_REQ;
         S_REQ:  if (!halt) state_nxt = S_WAIT;
         S_WAIT: state_nxt = S_HOLD;
         S_HOLD: if (instr_ready) state_nxt = S_REQ;
         default: state_nxt = S_RST;
      endcase
      if (redirect) state_nxt = S_REQ;
   end

   always_comb begin
      pc_nxt          = pc;
      rd_en_nxt       = 1'b0;
      instr_nxt       = instr;
      instr_pc_nxt    = instr_pc;
      valid_nxt       = instr_valid;
      fetch_count_nxt = fetch_count;
      if (redirect) begin
         // In-flight read data is simply never captured.
         pc_nxt    = pc_target;
         valid_nxt = 1'b0;
      end else begin
         unique case (state)
            S_REQ:  rd_en_nxt = !halt;
            S_WAIT: begin
               instr_nxt    = mem_rdata;
               instr_pc_nxt = pc;
               valid_nxt    = 1'b1;
               pc_nxt       = pc + ADDR_W'(1);
            end
            S_HOLD: if (instr_ready) begin
               valid_nxt       = 1'b0;
               fetch_count_nxt = fetch_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with fixed expected
// values plus randomized traffic checked against a transaction-level model.
module tb_instr_fetch;
   localparam int unsigned AW = 16;
   localparam logic [AW-1:0] RST_PC = 16'h0000;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] mem_addr;
   logic          mem_rd_en;
   logic [15:0]   mem_rdata;
   logic [15:0]   instr;
   logic [AW-1:0] instr_pc;
   logic          instr_valid;
   logic          instr_ready = 1'b0;
   logic          pc_load = 1'b0;
   logic [AW-1:0] pc_target = '0;
   logic          halt = 1'b0;
   logic [15:0]   fetch_count;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] ram [0:65535];

   // Model: pending read flag, held instruction, PC and accept count.
   logic [AW-1:0] m_pc, m_ipc;
   logic [15:0]   m_instr, m_cnt;
   logic          m_rd, m_valid, m_boot;

   always #5 clk = ~clk;

   always @(posedge clk) mem_rdata <= ram[mem_addr];

   instr_fetch #(.ADDR_W(AW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_load(pc_load),
      .pc_target(pc_target), .halt(halt), .fetch_count(fetch_count)
   );

   task automatic cycle();
      @(posedge clk);
      if (!reset) begin
         m_pc = RST_PC; m_rd = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_cnt = 0; m_boot = 1;
      end else if (m_boot) begin
         m_boot = 0;
      end else if (pc_load) begin
         m_pc = pc_target; m_valid = 0; m_rd = 0;
      end else if (m_rd) begin
         m_instr = ram[m_pc]; m_ipc = m_pc; m_pc = m_pc + 1'b1; m_valid = 1; m_rd = 0;
      end else if (m_valid) begin
         if (instr_ready) begin m_valid = 0; m_cnt = m_cnt + 16'd1; end
      end else begin
         m_rd = !halt;
      end
      #1;
   endtask

   function automatic logic [65:0] dut_vec();
      return {mem_addr, mem_rd_en, instr, instr_pc, instr_valid, fetch_count};
   endfunction

   function automatic logic [65:0] mdl_vec();
      return {m_pc, m_rd, m_instr, m_ipc, m_valid, m_cnt};
   endfunction

   task automatic test_reset();
      reset = 0; pc_load = 1; pc_target = 16'h1234; halt = 1; instr_ready = 1;
      cycle(); cycle();
      n_vec++;
      if ({mem_addr, mem_rd_en, instr, instr_pc, instr_valid, fetch_count} !== {RST_PC, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0}) begin
         n_err++;
         $display("FAIL reset_state: got addr=%h rd=%b instr=%h ipc=%h v=%b cnt=%h, want addr=%h rd=0 instr=0000 ipc=0000 v=0 cnt=0000",
                  mem_addr, mem_rd_en, instr, instr_pc, instr_valid, fetch_count, RST_PC);
      end
      pc_load = 0; halt = 0; instr_ready = 0;
   endtask

   task automatic test_free_run();
      reset = 0; cycle();
      reset = 1; instr_ready = 1;
      for (int i = 1; i <= 10; i++) begin
         cycle();
         n_vec++;
         if (instr_valid !== (i % 3 == 0)) begin
            n_err++; $display("FAIL free_run_valid@%0d: got %b want %b", i, instr_valid, (i % 3 == 0));
         end
         if (i % 3 == 0) begin
            n_vec++;
            if (instr !== 16'h0500 + 16'(i / 3 - 1) || instr_pc !== 16'(i / 3 - 1)) begin
               n_err++; $display("FAIL free_run_instr@%0d: got %h@%h want %h@%h", i, instr, instr_pc,
                                 16'h0500 + 16'(i / 3 - 1), 16'(i / 3 - 1));
            end
         end
      end
      n_vec++;
      if (fetch_count !== 16'd3) begin
         n_err++; $display("FAIL free_run_count: got %0d want 3", fetch_count);
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 0;
      cycle(); cycle();
      for (int i = 0; i < 6; i++) begin
         n_vec++;
         if ({instr_valid, instr, instr_pc, mem_rd_en, fetch_count} !== {1'b1, 16'h0503, 16'h0003, 1'b0, 16'd3}) begin
            n_err++; $display("FAIL backpressure_hold@%0d: got v=%b %h@%h rd=%b cnt=%0d want v=1 0503@0003 rd=0 cnt=3",
                              i, instr_valid, instr, instr_pc, mem_rd_en, fetch_count);
         end
         if (i < 5) cycle();
      end
      instr_ready = 1;
      cycle();
      instr_ready = 0;
      n_vec++;
      if (instr_valid !== 1'b0 || fetch_count !== 16'd4 || mem_addr !== 16'h0004) begin
         n_err++; $display("FAIL backpressure_release: got v=%b cnt=%0d addr=%h want v=0 cnt=4 addr=0004",
                           instr_valid, fetch_count, mem_addr);
      end
      cycle(); cycle();
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== 16'h0504 || instr_pc !== 16'h0004) begin
         n_err++; $display("FAIL backpressure_next: got v=%b %h@%h want v=1 0504@0004", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_redirect_wait();
      instr_ready = 1; cycle(); instr_ready = 0;
      for (int k = 0; k < 8 && mem_rd_en !== 1'b1; k++) cycle();
      n_vec++;
      if (mem_rd_en !== 1'b1) begin
         n_err++; $display("FAIL redirect_wait_reach: got rd=%b want 1", mem_rd_en);
      end
      pc_load = 1; pc_target = 16'h0040;
      cycle();
      pc_load = 0;
      for (int i = 0; i < 2; i++) begin
         n_vec++;
         if (instr_valid !== 1'b0 || mem_addr !== 16'h0040) begin
            n_err++; $display("FAIL redirect_wait_stale@%0d: got v=%b addr=%h want v=0 addr=0040", i, instr_valid, mem_addr);
         end
         cycle();
      end
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== 16'h0B12 || instr_pc !== 16'h0040 || fetch_count !== 16'd5) begin
         n_err++; $display("FAIL redirect_wait_target: got v=%b %h@%h cnt=%0d want v=1 0b12@0040 cnt=5",
                           instr_valid, instr, instr_pc, fetch_count);
      end
   endtask

   task automatic test_redirect_accept();
      pc_load = 1; pc_target = 16'h0100; instr_ready = 1;
      cycle();
      pc_load = 0; instr_ready = 0;
      n_vec++;
      if (fetch_count !== 16'd5 || instr_valid !== 1'b0 || mem_addr !== 16'h0100) begin
         n_err++; $display("FAIL redirect_accept: got cnt=%0d v=%b addr=%h want cnt=5 v=0 addr=0100",
                           fetch_count, instr_valid, mem_addr);
      end
      cycle(); cycle();
      n_vec++;
      if (instr_valid !== 1'b1 || instr !== 16'h0600 || instr_pc !== 16'h0100) begin
         n_err++; $display("FAIL redirect_accept_next: got v=%b %h@%h want v=1 0600@0100", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_halt();
      halt = 1; instr_ready = 1;
      cycle();
      instr_ready = 0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         n_vec++;
         if (mem_rd_en !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 16'h0101) begin
            n_err++; $display("FAIL halt_hold@%0d: got rd=%b v=%b addr=%h want rd=0 v=0 addr=0101", i, mem_rd_en, instr_valid, mem_addr);
         end
      end
      halt = 0;
      cycle();
      n_vec++;
      if (mem_rd_en !== 1'b1 || mem_addr !== 16'h0101) begin
         n_err++; $display("FAIL halt_resume: got rd=%b addr=%h want rd=1 addr=0101", mem_rd_en, mem_addr);
      end
      cycle();
      n_vec++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'h0101 || instr !== 16'h0601) begin
         n_err++; $display("FAIL halt_deliver: got v=%b %h@%h want v=1 0601@0101", instr_valid, instr, instr_pc);
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] acc [$];
      pc_load = 1; pc_target = 16'hFFFF;
      cycle();
      pc_load = 0; instr_ready = 1;
      for (int k = 0; k < 16 && acc.size() < 2; k++) begin
         if (instr_valid === 1'b1) acc.push_back(instr_pc);
         cycle();
      end
      instr_ready = 0;
      n_vec++;
      if (acc.size() != 2 || acc[0] !== 16'hFFFF || acc[1] !== 16'h0000) begin
         n_err++; $display("FAIL wrap_pc: got %0d accepts first=%h second=%h want ffff then 0000",
                           acc.size(), (acc.size() > 0) ? acc[0] : 16'hxxxx, (acc.size() > 1) ? acc[1] : 16'hxxxx);
      end
      for (int k = 0; k < 8 && instr_valid !== 1'b1; k++) cycle();
      n_vec++;
      if (instr_valid !== 1'b1) begin
         n_err++; $display("FAIL wrap_hold_reach: got v=%b want 1", instr_valid);
      end
      reset = 0;
      cycle();
      reset = 1;
      n_vec++;
      if (instr_valid !== 1'b0 || mem_addr !== RST_PC || fetch_count !== 16'd0 || instr !== 16'h0) begin
         n_err++; $display("FAIL reset_in_hold: got v=%b addr=%h cnt=%0d instr=%h want v=0 addr=%h cnt=0 instr=0000",
                           instr_valid, mem_addr, fetch_count, instr, RST_PC);
      end
   endtask

   task automatic test_random();
      reset = 0; cycle(); reset = 1;
      for (int i = 0; i < 3000; i++) begin
         reset       = ($urandom_range(0, 199) != 0);
         pc_load     = ($urandom_range(0, 15) == 0);
         pc_target   = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 3)) : 16'($urandom);
         halt        = ($urandom_range(0, 5) == 0);
         instr_ready = $urandom_range(0, 1);
         cycle();
         n_vec++;
         if (dut_vec() !== mdl_vec()) begin
            n_err++; $display("FAIL random@%0d: got %h want %h (addr,rd,instr,ipc,v,cnt)", i, dut_vec(), mdl_vec());
         end
      end
      reset = 1; pc_load = 0; halt = 0; instr_ready = 0;
   endtask

   initial begin
      for (int k = 0; k < 65536; k++) ram[k] = 16'h0500 + 16'(k);
      ram[16'h0040] = 16'h0B12;
      test_reset();
      test_free_run();
      test_backpressure();
      test_redirect_wait();
      test_redirect_accept();
      test_halt();
      test_wrap();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
